// File: rtl/key_entry_loader.sv
// Pushbutton hex-entry front end: three debounced keys build a 32-bit word a nibble at a
// time and hand it to a register-file write port under a valid/ready handshake.
module key_entry_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  key_n,
    input  logic [3:0]  sw_data,
    input  logic [4:0]  sw_reg,
    input  logic        wr_ready,
    output logic        wr_en,
    output logic [4:0]  wr_id,
    output logic [31:0] wr_data,
    output logic [31:0] entry_data,
    output logic [3:0]  nibble_count,
    output logic        busy
);

    localparam logic [19:0] W_LIMIT = 20'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_WRITE
    } state_t;

    logic [2:0]  r_meta;
    logic [2:0]  r_sync;
    logic [2:0]  w_press;

    state_t      r_state;
    logic        r_wr_en;
    logic [4:0]  r_wr_id;
    logic [31:0] r_wr_data;
    logic [31:0] r_entry;
    logic [3:0]  r_count;

    // Keys idle high, so the synchronizer resets to the released level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= key_n;
            r_sync <= r_meta;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            logic        r_level;
            logic [19:0] r_cnt;
            logic        r_press;

            // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_level <= 1'b1;
                    r_cnt   <= '0;
                    r_press <= 1'b0;
                end else begin
                    r_press <= 1'b0;
                    if (r_sync[gi] == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt + 20'd1 >= W_LIMIT) begin
                        r_cnt   <= '0;
                        r_level <= ~r_level;
                        r_press <= r_level;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_wr_id   <= '0;
            r_wr_data <= '0;
            r_entry   <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_WRITE: begin
                    // Key pulses are dropped here; the write fields stay frozen until accepted.
                    if (wr_ready) begin
                        r_wr_en <= 1'b0;
                        r_entry <= '0;
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    if (w_press[2]) begin
                        r_entry <= '0;
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end else if (w_press[1]) begin
                        if (r_state == S_ENTRY) begin
                            if (sw_reg != 5'd0) begin
                                r_wr_en   <= 1'b1;
                                r_wr_id   <= sw_reg;
                                r_wr_data <= r_entry;
                                r_state   <= S_WRITE;
                            end else begin
                                r_entry <= '0;
                                r_count <= '0;
                                r_state <= S_IDLE;
                            end
                        end
                    end else if (w_press[0]) begin
                        r_entry <= {r_entry[27:0], sw_data};
                        if (r_count != 4'd8) begin
                            r_count <= r_count + 4'd1;
                        end
                        r_state <= S_ENTRY;
                    end
                end
            endcase
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_id        = r_wr_id;
    assign wr_data      = r_wr_data;
    assign entry_data   = r_entry;
    assign nibble_count = r_count;
    assign busy         = (r_state == S_WRITE);

endmodule

// File: tb/tb_key_entry_loader.sv
// Bench for key_entry_loader: directed scenarios plus randomized key activity, all checked
// every cycle against a behavioural model of keys, entry word and pending write.
module tb_key_entry_loader;

    localparam int D = 4;

    logic        clock;
    logic        reset;
    logic [2:0]  key_n;
    logic [3:0]  sw_data;
    logic [4:0]  sw_reg;
    logic        wr_ready;
    logic        wr_en;
    logic [4:0]  wr_id;
    logic [31:0] wr_data;
    logic [31:0] entry_data;
    logic [3:0]  nibble_count;
    logic        busy;

    key_entry_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .key_n        (key_n),
        .sw_data      (sw_data),
        .sw_reg       (sw_reg),
        .wr_ready     (wr_ready),
        .wr_en        (wr_en),
        .wr_id        (wr_id),
        .wr_data      (wr_data),
        .entry_data   (entry_data),
        .nibble_count (nibble_count),
        .busy         (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_errors = 0;
    int m_hi     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw keys pass through two sample delays; a key's level flips once it has
    // disagreed for D samples in a row; a 1->0 flip is a press seen one cycle later.
    // "Something entered" is simply a non-zero nibble count.
    logic [2:0]  m_meta, m_sync, m_level, m_press;
    int          m_run [3];
    logic        m_busy;
    logic [4:0]  m_id;
    logic [31:0] m_data, m_entry;
    logic [3:0]  m_count;
    logic        m_valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_meta  = '1;
            m_sync  = '1;
            m_level = '1;
            m_press = '0;
            for (int k = 0; k < 3; k++) m_run[k] = 0;
            m_busy  = 1'b0;
            m_id    = '0;
            m_data  = '0;
            m_entry = '0;
            m_count = '0;
            m_valid = 1'b1;
        end else begin
            if (m_busy) begin
                if (wr_ready) begin
                    m_busy  = 1'b0;
                    m_entry = '0;
                    m_count = '0;
                end
            end else if (m_press[2]) begin
                m_entry = '0;
                m_count = '0;
            end else if (m_press[1]) begin
                if (m_count != 0) begin
                    if (sw_reg != 0) begin
                        m_busy = 1'b1;
                        m_id   = sw_reg;
                        m_data = m_entry;
                    end else begin
                        m_entry = '0;
                        m_count = '0;
                    end
                end
            end else if (m_press[0]) begin
                m_entry = (m_entry << 4) | 32'(sw_data);
                if (m_count < 8) m_count = m_count + 4'd1;
            end
            for (int k = 0; k < 3; k++) begin
                m_press[k] = 1'b0;
                if (m_sync[k] != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_level[k] = ~m_level[k];
                        m_run[k]   = 0;
                        m_press[k] = ~m_level[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_sync = m_meta;
            m_meta = key_n;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("wr_en",        32'(wr_en),        32'(m_busy));
            chk("busy",         32'(busy),         32'(m_busy));
            chk("wr_id",        32'(wr_id),        32'(m_id));
            chk("wr_data",      wr_data,           m_data);
            chk("entry_data",   entry_data,        m_entry);
            chk("nibble_count", 32'(nibble_count), 32'(m_count));
        end
        if (wr_en) m_hi++;
    end

    task automatic press(input logic [2:0] mask);
        key_n = ~mask;
        repeat (D + 8) @(negedge clock);
        key_n = 3'b111;
        repeat (D + 8) @(negedge clock);
    endtask

    task automatic enter(input logic [3:0] v);
        sw_data = v;
        press(3'b001);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic got;
        reset    = 1'b1;
        key_n    = 3'b111;
        sw_data  = '0;
        sw_reg   = '0;
        wr_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_entry", entry_data, 0);
        chk("rst_count", 32'(nibble_count), 0);
        chk("rst_wr_id", 32'(wr_id), 0);
        chk("rst_wr_data", wr_data, 0);

        // Bouncing enter key settles to a single press.
        sw_data = 4'h3;
        for (int i = 0; i < 20; i++) begin
            key_n[0] = 1'((i / 2) % 2);
            @(negedge clock);
        end
        key_n[0] = 1'b0;
        repeat (D + 8) @(negedge clock);
        key_n[0] = 1'b1;
        repeat (D + 8) @(negedge clock);
        chk("bounce_count", 32'(nibble_count), 1);
        chk("bounce_entry", entry_data, 32'h3);
        press(3'b100);
        chk("clear_count", 32'(nibble_count), 0);

        // Nine nibbles: the first falls off the top, count saturates.
        for (int v = 1; v <= 9; v++) enter(4'(v));
        chk("nine_entry", entry_data, 32'h2345_6789);
        chk("nine_count", 32'(nibble_count), 8);
        press(3'b100);

        // Commit with a stalled write port.
        enter(4'hA);
        enter(4'hB);
        sw_reg   = 5'd5;
        wr_ready = 1'b0;
        m_hi     = 0;
        key_n    = 3'b101;
        got      = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (wr_en) got = 1'b1;
        end
        chk("commit_seen", 32'(got), 1);
        chk("commit_id", 32'(wr_id), 5);
        chk("commit_data", wr_data, 32'hAB);
        repeat (10) @(negedge clock);
        wr_ready = 1'b1;
        @(negedge clock);
        wr_ready = 1'b0;
        chk("commit_hi_cycles", 32'(m_hi), 11);
        chk("commit_done_en", 32'(wr_en), 0);
        chk("commit_done_busy", 32'(busy), 0);
        chk("commit_done_entry", entry_data, 0);
        key_n = 3'b111;
        repeat (D + 8) @(negedge clock);

        // Commit to register 0 discards the entry without writing.
        m_hi = 0;
        enter(4'h7);
        sw_reg = 5'd0;
        press(3'b010);
        chk("reg0_no_write", 32'(m_hi), 0);
        chk("reg0_entry", entry_data, 0);
        chk("reg0_count", 32'(nibble_count), 0);

        // Clear beats enter when both land together.
        enter(4'h5);
        sw_data = 4'h5;
        press(3'b101);
        chk("clr_enter_entry", entry_data, 0);
        chk("clr_enter_count", 32'(nibble_count), 0);

        // Keys are ignored while a write is pending.
        enter(4'h1);
        enter(4'h2);
        sw_reg = 5'd9;
        press(3'b010);
        enter(4'hF);
        press(3'b100);
        chk("write_hold_busy", 32'(busy), 1);
        chk("write_hold_entry", entry_data, 32'h12);
        chk("write_hold_data", wr_data, 32'h12);
        chk("write_hold_id", 32'(wr_id), 9);
        wr_ready = 1'b1;
        @(negedge clock);
        wr_ready = 1'b0;
        chk("write_hold_done", 32'(busy), 0);

        // Reset during a pending write drops it.
        enter(4'h3);
        sw_reg = 5'd4;
        press(3'b010);
        chk("pre_reset_en", 32'(wr_en), 1);
        reset    = 1'b1;
        wr_ready = 1'b1;
        key_n    = 3'b000;
        @(negedge clock);
        reset    = 1'b0;
        wr_ready = 1'b0;
        key_n    = 3'b111;
        chk("mid_reset_en", 32'(wr_en), 0);
        chk("mid_reset_busy", 32'(busy), 0);
        chk("mid_reset_id", 32'(wr_id), 0);
        chk("mid_reset_data", wr_data, 0);
        chk("mid_reset_entry", entry_data, 0);
        chk("mid_reset_count", 32'(nibble_count), 0);
        m_hi = 0;
        repeat (D + 8) @(negedge clock);
        chk("post_reset_no_en", 32'(m_hi), 0);

        // Randomized key activity with bounce, random write back-pressure and rare resets.
        for (int seg = 0; seg < 400; seg++) begin
            int r;
            int k;
            logic [2:0] target;
            r       = int'($urandom_range(0, 99));
            sw_data = 4'($urandom);
            sw_reg  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (r < 2) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            if (r < 45) begin
                target = 3'b111;
            end else begin
                k = int'($urandom_range(0, 9));
                target = (k < 5) ? 3'b110 : (k < 8) ? 3'b101 : 3'b011;
            end
            for (int b = 0; b < int'($urandom_range(0, 6)); b++) begin
                key_n    = 3'($urandom);
                wr_ready = ($urandom_range(0, 2) == 0);
                @(negedge clock);
            end
            key_n = target;
            for (int h = 0; h < int'($urandom_range(1, 12)); h++) begin
                wr_ready = ($urandom_range(0, 2) == 0);
                @(negedge clock);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
